// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter and its
// late-return FIFO.
package rf_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] LAST_REG = 5'(NUM_REGS - 1);

    typedef enum logic {INIT, RUN} state_e;

    typedef enum logic [2:0] {G_NONE, G_INIT, G_CORE, G_FIFO, G_DBG} grant_e;

    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
        return addr == 5'd0;
    endfunction

endpackage

// File: rtl/rf_late_fifo.sv
// Circular buffer holding late-return writes, with address lookup across all
// valid entries for read-after-write hazard detection.
module rf_late_fifo
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic [REG_ADDR_W-1:0]   push_addr_i,
    input  logic [XLEN-1:0]         push_data_i,
    input  logic                    pop_i,
    input  logic [REG_ADDR_W-1:0]   lookup1_i,
    input  logic [REG_ADDR_W-1:0]   lookup2_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic [REG_ADDR_W-1:0]   head_addr_o,
    output logic [XLEN-1:0]         head_data_o,
    output logic                    match1_o,
    output logic                    match2_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic [REG_ADDR_W-1:0]  addr_mem_q [DEPTH];
    logic [XLEN-1:0]        data_mem_q [DEPTH];

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below count_q, so no reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_mem_q[wr_ptr_q] <= push_addr_i;
            data_mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Hazard lookup over every valid entry, head included even when popping.
    always_comb begin
        match1_o = 1'b0;
        match2_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            match1_o = match1_o | (((AW+1)'(i) < count_q) &&
                                   (addr_mem_q[rd_ptr_q + AW'(i)] == lookup1_i));
            match2_o = match2_o | (((AW+1)'(i) < count_q) &&
                                   (addr_mem_q[rd_ptr_q + AW'(i)] == lookup2_i));
        end
    end

    assign count_o     = count_q;
    assign head_addr_o = addr_mem_q[rd_ptr_q];
    assign head_data_o = data_mem_q[rd_ptr_q];

endmodule

// File: rtl/rf_write_arbiter.sv
// Single register-file write port shared by core writeback, buffered late
// returns and debug; clears x1..x31 after reset before handing over.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    core_wb_en,
    input  logic [4:0]              core_wb_addr,
    input  logic [31:0]             core_wb_data,
    input  logic                    late_valid,
    output logic                    late_ready,
    input  logic [4:0]              late_addr,
    input  logic [31:0]             late_data,
    input  logic                    dbg_valid,
    output logic                    dbg_ready,
    input  logic [4:0]              dbg_addr,
    input  logic [31:0]             dbg_data,
    input  logic [4:0]              rd_addr1,
    input  logic [4:0]              rd_addr2,
    output logic                    rd_hazard1,
    output logic                    rd_hazard2,
    output logic                    rf_wrt_en,
    output logic [4:0]              rf_wrt_addr,
    output logic [31:0]             rf_wrt_data,
    output logic                    init_busy,
    output logic [$clog2(DEPTH):0]  fifo_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    state_e                 state_q, state_d;
    logic [REG_ADDR_W-1:0]  init_cnt_q, init_cnt_d;
    logic [SW-1:0]          starve_q, starve_d;
    grant_e                 grant_s;
    logic                   push_s, pop_s, dbg_req_s;
    logic [CW-1:0]          count_s;
    logic [REG_ADDR_W-1:0]  head_addr_s;
    logic [XLEN-1:0]        head_data_s;
    logic                   match1_s, match2_s;

    rf_late_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_s),
        .push_addr_i (late_addr),
        .push_data_i (late_data),
        .pop_i       (pop_s),
        .lookup1_i   (rd_addr1),
        .lookup2_i   (rd_addr2),
        .count_o     (count_s),
        .head_addr_o (head_addr_s),
        .head_data_o (head_data_s),
        .match1_o    (match1_s),
        .match2_o    (match2_s)
    );

    // Debug to x0 needs no port cycle, so it never competes for a grant.
    assign dbg_req_s = dbg_valid && !is_x0(dbg_addr);

    // Next state, grant selection and handshakes.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        grant_s    = G_NONE;
        late_ready = 1'b0;
        dbg_ready  = 1'b0;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        case (state_q)
            INIT: begin
                grant_s    = G_INIT;
                init_cnt_d = init_cnt_q + 5'd1;
                if (init_cnt_q == LAST_REG) begin
                    state_d = RUN;
                end else begin
                    state_d = INIT;
                end
            end
            RUN: begin
                late_ready = count_s < CW'(DEPTH);
                push_s     = late_valid && late_ready && !is_x0(late_addr);
                if (core_wb_en && !is_x0(core_wb_addr)) begin
                    grant_s = G_CORE;
                end else if (dbg_req_s && (starve_q == SW'(STARVE_MAX))) begin
                    grant_s = G_DBG;
                end else if (count_s != CW'(0)) begin
                    grant_s = G_FIFO;
                end else if (dbg_req_s) begin
                    grant_s = G_DBG;
                end else begin
                    grant_s = G_NONE;
                end
                pop_s     = grant_s == G_FIFO;
                dbg_ready = (grant_s == G_DBG) || (dbg_valid && is_x0(dbg_addr));
            end
            default: state_d = INIT;
        endcase
    end

    // Starvation counter: counts debug losses, saturating at promotion level.
    always_comb begin
        starve_d = starve_q;
        if (!dbg_valid || dbg_ready) begin
            starve_d = SW'(0);
        end else if (starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Write-port mux driven by the winning source.
    always_comb begin
        rf_wrt_en   = 1'b0;
        rf_wrt_addr = 5'd0;
        rf_wrt_data = 32'd0;
        case (grant_s)
            G_INIT: begin
                rf_wrt_en   = 1'b1;
                rf_wrt_addr = init_cnt_q;
            end
            G_CORE: begin
                rf_wrt_en   = 1'b1;
                rf_wrt_addr = core_wb_addr;
                rf_wrt_data = core_wb_data;
            end
            G_FIFO: begin
                rf_wrt_en   = 1'b1;
                rf_wrt_addr = head_addr_s;
                rf_wrt_data = head_data_s;
            end
            G_DBG: begin
                rf_wrt_en   = 1'b1;
                rf_wrt_addr = dbg_addr;
                rf_wrt_data = dbg_data;
            end
            default: begin
                rf_wrt_en   = 1'b0;
                rf_wrt_addr = 5'd0;
                rf_wrt_data = 32'd0;
            end
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= INIT;
            init_cnt_q <= 5'd1;
            starve_q   <= SW'(0);
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            starve_q   <= starve_d;
        end
    end

    assign rd_hazard1 = match1_s && !is_x0(rd_addr1);
    assign rd_hazard2 = match2_s && !is_x0(rd_addr2);
    assign init_busy  = state_q == INIT;
    assign fifo_count = count_s;

endmodule
